fm_demod: RTL
=============

FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, sample/angle word width.
REQ-002 SHALL have parameter BITS, default 10, fixed-point fraction bits.
REQ-003 SHALL have parameter GAIN, default 32'h000002F6, demod gain, Q.BITS.
REQ-004 SHALL have port clock  input  1  sole clock; rising-edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_empty  input  1  upstream FWFT FIFO empty.
REQ-007 SHALL have port in_rd_en  output  1  pop one I/Q pair from upstream.
REQ-008 SHALL have port real_in  input  DATA_SIZE  signed I sample, valid when !in_empty.
REQ-009 SHALL have port imag_in  input  DATA_SIZE  signed Q sample, valid when !in_empty.
REQ-010 SHALL have port out_full  input  1  downstream FIFO full.
REQ-011 SHALL have port out_wr_en  output  1  push demod_out downstream.
REQ-012 SHALL have port demod_out  output  DATA_SIZE  signed demodulated sample.

Function
REQ-013 SHALL hold registers prev_r, prev_i (previous sample) and cur_r, cur_i.
REQ-014 SHALL define DQ(x) as shift right by BITS, truncating toward zero: x<0 -> -((-x)>>>BITS).
REQ-015 SHALL form full 2*DATA_SIZE signed products; DQ is applied before truncation to DATA_SIZE.
REQ-016 SHALL compute r = DQ(prev_r*cur_r) - DQ(-prev_i*cur_i), i = DQ(prev_r*cur_i) + DQ(-prev_i*cur_r).
REQ-017 SHALL drive qarctan real_ = r, imag = i, both held constant from start pulse until qarctan done.
REQ-018 SHALL compute demod_out = DQ(GAIN * angle), where angle is the qarctan data_out captured on done.
REQ-019 SHALL use FSM states IDLE, MULT, ADD, ATAN_START, ATAN_WAIT, GAIN, WRITE.
REQ-020 In IDLE, if !in_empty: in_rd_en=1 for one cycle, latch cur_r/cur_i -> MULT; otherwise remain in IDLE.
REQ-021 MULT SHALL register the four DQ'd products -> ADD.
REQ-022 ADD SHALL register r and i, update prev_r/prev_i <= cur_r/cur_i -> ATAN_START.
REQ-023 ATAN_START SHALL pulse qarctan start_signal high exactly one cycle -> ATAN_WAIT.
REQ-024 ATAN_WAIT SHALL wait on qarctan done_signal, capture data_out -> GAIN; no timeout.
REQ-025 GAIN SHALL register demod_out -> WRITE.
REQ-026 In WRITE, if !out_full: out_wr_en=1 for one cycle -> IDLE; else hold with out_wr_en=0 and demod_out stable.
REQ-027 SHALL process at most one sample in flight; in_rd_en SHALL never assert outside IDLE.
REQ-028 in_rd_en and out_wr_en SHALL be combinational from state plus in_empty/out_full only.
REQ-029 First sample after reset SHALL use prev = (0,0).
REQ-030 Overflow SHALL wrap modulo 2^DATA_SIZE without saturation.

Reset
REQ-031 On reset: state=IDLE; prev_r, prev_i, cur_r, cur_i, r, i, angle, demod_out = 0; in_rd_en=0, out_wr_en=0.
REQ-032 Reset in any state, including ATAN_WAIT and WRITE, SHALL abort the sample with no write and no pop.
REQ-033 Reset SHALL also reset the qarctan instance.

Structure
REQ-034 Package fm_radio_pkg SHALL hold DATA_SIZE, BITS, GAIN, QUANTIZE/DEQUANTIZE functions, shared with qarctan.
REQ-035 FSM state enum SHALL be local to fm_demod.
REQ-036 SHALL instantiate exactly one sub-module, qarctan (DATA_SIZE), driven from the same clock/reset.

Verification
REQ-037 Reset, then in_empty=1 for 10 cycles -> in_rd_en=0, out_wr_en=0, demod_out=0.
REQ-038 Single sample (1024,0) after reset -> qarctan sees r=0,i=0, returns 0x648; demod_out=DQ(758*1608)=1190; one out_wr_en pulse.
REQ-039 Samples (1024,0),(1024,0) -> second pass presents r=1024,i=0 to qarctan; demod_out=DQ(758*angle).
REQ-040 prev=(1000,0), cur=(-1,0) -> r=0 (truncation toward zero, not -1), i=0.
REQ-041 out_full held high 5 cycles in WRITE -> out_wr_en=0, demod_out stable, in_rd_en=0; single write once released.
REQ-042 Reset asserted during ATAN_WAIT -> next cycle IDLE, no write, prev=(0,0); next sample is treated as first.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Fixed-point constants and quantize helpers shared by the FM radio datapath blocks.
package fm_radio_pkg;

  localparam int DATA_SIZE = 32;
  localparam int BITS      = 10;
  localparam int PROD_SIZE = 2 * DATA_SIZE;
  localparam logic [DATA_SIZE-1:0] GAIN = 32'h000002F6;

  // pi/4 and 3*pi/4 expressed in Q.BITS
  localparam int QUAD1 = 804;
  localparam int QUAD3 = 2412;

  function automatic logic signed [DATA_SIZE-1:0] QUANTIZE(
    input logic signed [DATA_SIZE-1:0] x,
    input int                          bits
  );
    return x <<< bits;
  endfunction

  // Truncates toward zero (a bare arithmetic shift would round negatives down),
  // then keeps the low DATA_SIZE bits so overflow wraps.
  function automatic logic signed [DATA_SIZE-1:0] DEQUANTIZE(
    input logic signed [PROD_SIZE-1:0] x,
    input int                          bits
  );
    return x[PROD_SIZE-1] ? DATA_SIZE'(-((-x) >>> bits)) : DATA_SIZE'(x >>> bits);
  endfunction

endpackage

// File: rtl/fm_demod_qarctan.sv
// Quadrant-approximated arctangent of (real_, imag) using a bit-serial divider.
module qarctan #(
  parameter int DATA_SIZE = fm_radio_pkg::DATA_SIZE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_signal,
  input  logic signed [DATA_SIZE-1:0] real_,
  input  logic signed [DATA_SIZE-1:0] imag,
  output logic signed [DATA_SIZE-1:0] data_out,
  output logic                        done_signal
);

  localparam int PW = 2 * DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE + 1);

  localparam logic [1:0] Q_IDLE = 2'd0;
  localparam logic [1:0] Q_DIV  = 2'd1;
  localparam logic [1:0] Q_FIN  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [DATA_SIZE-1:0]        rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        q_neg_q, q_neg_d, x_neg_q, x_neg_d, y_neg_q, y_neg_d;
  logic signed [DATA_SIZE-1:0] out_q, out_d;
  logic                        done_q, done_d;

  logic signed [DATA_SIZE-1:0] abs_y, diff, num, den;
  logic [DATA_SIZE:0]          rem_shift, rem_sub;
  logic signed [DATA_SIZE-1:0] quot, quad, dq, angle;
  logic signed [PW-1:0]        prod;

  assign data_out    = out_q;
  assign done_signal = done_q;

  // Divider runs on magnitudes; the C-style truncating sign is reapplied afterwards.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    x_neg_d = x_neg_q;
    y_neg_d = y_neg_q;
    out_d   = out_q;
    done_d  = 1'b0;

    abs_y = (imag[DATA_SIZE-1] ? -imag : imag) + DATA_SIZE'(1);
    diff  = real_[DATA_SIZE-1] ? (real_ + abs_y) : (real_ - abs_y);
    den   = real_[DATA_SIZE-1] ? (abs_y - real_) : (real_ + abs_y);
    num   = fm_radio_pkg::QUANTIZE(diff, fm_radio_pkg::BITS);

    rem_shift = {rem_q, quo_q[DATA_SIZE-1]};
    rem_sub   = rem_shift - {1'b0, den_q};

    quot  = q_neg_q ? -quo_q : quo_q;
    quad  = x_neg_q ? DATA_SIZE'(fm_radio_pkg::QUAD3) : DATA_SIZE'(fm_radio_pkg::QUAD1);
    prod  = PW'(DATA_SIZE'(fm_radio_pkg::QUAD1)) * PW'(quot);
    dq    = fm_radio_pkg::DEQUANTIZE(prod, fm_radio_pkg::BITS);
    angle = quad - dq;

    case (state_q)
      Q_IDLE: begin
        if (start_signal) begin
          rem_d   = '0;
          quo_d   = num[DATA_SIZE-1] ? -num : num;
          den_d   = den[DATA_SIZE-1] ? -den : den;
          q_neg_d = num[DATA_SIZE-1] ^ den[DATA_SIZE-1];
          x_neg_d = real_[DATA_SIZE-1];
          y_neg_d = imag[DATA_SIZE-1];
          cnt_d   = '0;
          state_d = Q_DIV;
        end
      end
      Q_DIV: begin
        if (!rem_sub[DATA_SIZE]) begin
          rem_d = rem_sub[DATA_SIZE-1:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DATA_SIZE-1:0];
          quo_d = {quo_q[DATA_SIZE-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_SIZE - 1)) state_d = Q_FIN;
      end
      Q_FIN: begin
        out_d   = y_neg_q ? -angle : angle;
        done_d  = 1'b1;
        state_d = Q_IDLE;
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Q_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      x_neg_q <= 1'b0;
      y_neg_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      x_neg_q <= x_neg_d;
      y_neg_q <= y_neg_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/fm_demod.sv
// FM demodulator: conjugate-multiplies consecutive I/Q samples and scales the phase step.
module fm_demod #(
  parameter int                   DATA_SIZE = fm_radio_pkg::DATA_SIZE,
  parameter int                   BITS      = fm_radio_pkg::BITS,
  parameter logic [DATA_SIZE-1:0] GAIN      = fm_radio_pkg::GAIN
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_empty,
  output logic                        in_rd_en,
  input  logic signed [DATA_SIZE-1:0] real_in,
  input  logic signed [DATA_SIZE-1:0] imag_in,
  input  logic                        out_full,
  output logic                        out_wr_en,
  output logic signed [DATA_SIZE-1:0] demod_out
);

  localparam int PW = 2 * DATA_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_MULT, S_ADD, S_ATAN_START, S_ATAN_WAIT, S_GAIN, S_WRITE
  } state_t;

  state_t                      state_q, state_d;
  logic signed [DATA_SIZE-1:0] prev_r_q, prev_r_d, prev_i_q, prev_i_d;
  logic signed [DATA_SIZE-1:0] cur_r_q, cur_r_d, cur_i_q, cur_i_d;
  logic signed [DATA_SIZE-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [DATA_SIZE-1:0] r_q, r_d, i_q, i_d;
  logic signed [DATA_SIZE-1:0] angle_q, angle_d, demod_q, demod_d;
  logic signed [DATA_SIZE-1:0] atan_out;
  logic                        atan_done, atan_start;

  assign in_rd_en   = (state_q == S_IDLE) && !in_empty;
  assign out_wr_en  = (state_q == S_WRITE) && !out_full;
  assign atan_start = (state_q == S_ATAN_START);
  assign demod_out  = demod_q;

  qarctan #(.DATA_SIZE(DATA_SIZE)) u_qarctan (
    .clock       (clock),
    .reset       (reset),
    .start_signal(atan_start),
    .real_       (r_q),
    .imag        (i_q),
    .data_out    (atan_out),
    .done_signal (atan_done)
  );

  always_comb begin
    state_d  = state_q;
    prev_r_d = prev_r_q;
    prev_i_d = prev_i_q;
    cur_r_d  = cur_r_q;
    cur_i_d  = cur_i_q;
    rr_d     = rr_q;
    ii_d     = ii_q;
    ri_d     = ri_q;
    ir_d     = ir_q;
    r_d      = r_q;
    i_d      = i_q;
    angle_d  = angle_q;
    demod_d  = demod_q;

    case (state_q)
      S_IDLE: begin
        if (!in_empty) begin
          cur_r_d = real_in;
          cur_i_d = imag_in;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        rr_d    = fm_radio_pkg::DEQUANTIZE(PW'(prev_r_q) * PW'(cur_r_q), BITS);
        ii_d    = fm_radio_pkg::DEQUANTIZE(-PW'(prev_i_q) * PW'(cur_i_q), BITS);
        ri_d    = fm_radio_pkg::DEQUANTIZE(PW'(prev_r_q) * PW'(cur_i_q), BITS);
        ir_d    = fm_radio_pkg::DEQUANTIZE(-PW'(prev_i_q) * PW'(cur_r_q), BITS);
        state_d = S_ADD;
      end
      S_ADD: begin
        r_d      = rr_q - ii_q;
        i_d      = ri_q + ir_q;
        prev_r_d = cur_r_q;
        prev_i_d = cur_i_q;
        state_d  = S_ATAN_START;
      end
      S_ATAN_START: state_d = S_ATAN_WAIT;
      S_ATAN_WAIT: begin
        if (atan_done) begin
          angle_d = atan_out;
          state_d = S_GAIN;
        end
      end
      S_GAIN: begin
        demod_d = fm_radio_pkg::DEQUANTIZE(PW'(signed'(GAIN)) * PW'(angle_q), BITS);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prev_r_q <= '0;
      prev_i_q <= '0;
      cur_r_q  <= '0;
      cur_i_q  <= '0;
      rr_q     <= '0;
      ii_q     <= '0;
      ri_q     <= '0;
      ir_q     <= '0;
      r_q      <= '0;
      i_q      <= '0;
      angle_q  <= '0;
      demod_q  <= '0;
    end else begin
      state_q  <= state_d;
      prev_r_q <= prev_r_d;
      prev_i_q <= prev_i_d;
      cur_r_q  <= cur_r_d;
      cur_i_q  <= cur_i_d;
      rr_q     <= rr_d;
      ii_q     <= ii_d;
      ri_q     <= ri_d;
      ir_q     <= ir_d;
      r_q      <= r_d;
      i_q      <= i_d;
      angle_q  <= angle_d;
      demod_q  <= demod_d;
    end
  end

endmodule
